// File: rtl/seg_scan_driver.sv
// seg_scan_driver: multi-bank multiplexed 7-segment display driver.
// All banks share one digit scan. Display data is latched into shadow
// registers only at frame boundaries, so the screen never tears.
// Outputs are active-low and registered. The digit-0 slot of the first
// frame after reset or re-enable is one cycle shorter, because that first
// cycle is spent capturing fresh data while the outputs stay dark.
module seg_scan_driver #(
    parameter int NUM_BANKS    = 2,
    parameter int DIGITS       = 4,
    parameter int SCAN_DIV     = 65536,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [NUM_BANKS*DIGITS*4-1:0] digit_data,
    input  logic [NUM_BANKS*DIGITS-1:0]   blank_mask,
    input  logic [NUM_BANKS*DIGITS-1:0]   blink_mask,
    input  logic [NUM_BANKS*DIGITS-1:0]   dp_mask,
    output logic [NUM_BANKS*DIGITS-1:0]   an,
    output logic [NUM_BANKS*8-1:0]        sseg,
    output logic                          frame_start
);

    localparam int N  = NUM_BANKS * DIGITS;
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

    // Hex code to active-low segments {a,b,c,d,e,f,g}; code F is blank.
    function automatic logic [6:0] seg_decode(input logic [3:0] code);
        logic [6:0] seg;
        case (code)
            4'h0:    seg = 7'b0000001;
            4'h1:    seg = 7'b1001111;
            4'h2:    seg = 7'b0010010;
            4'h3:    seg = 7'b0000110;
            4'h4:    seg = 7'b1001100;
            4'h5:    seg = 7'b0100100;
            4'h6:    seg = 7'b0100000;
            4'h7:    seg = 7'b0001111;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0000100;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b1100000;
            4'hC:    seg = 7'b0110001;
            4'hD:    seg = 7'b1000010;
            4'hE:    seg = 7'b0110000;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

    logic [PW-1:0]   r_presc;
    logic [IW-1:0]   r_idx;
    logic [FW-1:0]   r_frame;
    logic            r_blink;
    logic            r_first;      // next enabled cycle is a start-up capture
    logic [N*4-1:0]  r_sh_data;
    logic [N-1:0]    r_sh_blank;
    logic [N-1:0]    r_sh_blink;
    logic [N-1:0]    r_sh_dp;
    logic [N-1:0]    r_an;
    logic [NUM_BANKS*8-1:0] r_sseg;
    logic            r_frame_start;

    logic            w_tick;
    logic            w_frame_end;
    logic            w_capture;
    logic [N-1:0]    w_an_next;
    logic [NUM_BANKS*8-1:0] w_sseg_next;

    assign w_tick      = (r_presc == PRESC_LAST);
    assign w_frame_end = w_tick && (r_idx == IDX_LAST);
    assign w_capture   = r_first || w_frame_end;

    // Decode the currently selected digit of every bank from shadow data.
    always_comb begin
        w_an_next   = '1;
        w_sseg_next = '1;
        for (int b = 0; b < NUM_BANKS; b++) begin
            for (int d = 0; d < DIGITS; d++) begin
                if (r_idx == IW'(d)) begin
                    // Anode stays on for a dark digit so slot timing is uniform.
                    w_an_next[b*DIGITS+d] = 1'b0;
                    if (!(r_sh_blank[b*DIGITS+d] ||
                          (r_sh_blink[b*DIGITS+d] && r_blink))) begin
                        w_sseg_next[b*8 +: 8] = {~r_sh_dp[b*DIGITS+d],
                                                 seg_decode(r_sh_data[(b*DIGITS+d)*4 +: 4])};
                    end
                end
            end
        end
    end

    // Scan timing, frame/blink counting, shadow capture and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc       <= '0;
            r_idx         <= '0;
            r_frame       <= '0;
            r_blink       <= 1'b0;
            r_first       <= 1'b1;
            r_sh_data     <= '0;
            r_sh_blank    <= '0;
            r_sh_blink    <= '0;
            r_sh_dp       <= '0;
            r_an          <= '1;
            r_sseg        <= '1;
            r_frame_start <= 1'b0;
        end else if (!enable) begin
            // Dark and idle; shadows retain their contents.
            r_presc       <= '0;
            r_idx         <= '0;
            r_frame       <= '0;
            r_blink       <= 1'b0;
            r_first       <= 1'b1;
            r_an          <= '1;
            r_sseg        <= '1;
            r_frame_start <= 1'b0;
        end else begin
            r_first       <= 1'b0;
            r_frame_start <= w_capture;

            if (w_tick) begin
                r_presc <= '0;
                r_idx   <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
            end else begin
                r_presc <= r_presc + 1'b1;
            end

            if (w_capture) begin
                r_sh_data  <= digit_data;
                r_sh_blank <= blank_mask;
                r_sh_blink <= blink_mask;
                r_sh_dp    <= dp_mask;
            end

            if (w_frame_end) begin
                if (r_frame == FRAME_LAST) begin
                    r_frame <= '0;
                    r_blink <= ~r_blink;
                end else begin
                    r_frame <= r_frame + 1'b1;
                end
            end

            // Stay dark in the start-up capture cycle so stale shadow data
            // never reaches the pins.
            if (r_first) begin
                r_an   <= '1;
                r_sseg <= '1;
            end else begin
                r_an   <= w_an_next;
                r_sseg <= w_sseg_next;
            end
        end
    end

    assign an          = r_an;
    assign sseg        = r_sseg;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Testbench for seg_scan_driver. Expected outputs are predicted per edge
// from a timeline model (edges since the scan started) and queued, then
// popped and compared after each edge.
module tb_seg_scan_driver;

    localparam int NB = 2;
    localparam int D  = 4;
    localparam int SD = 4;
    localparam int BF = 2;
    localparam int N  = NB * D;
    localparam int EW = N + NB * 8 + 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic [N*4-1:0]    digit_data;
    logic [N-1:0]      blank_mask;
    logic [N-1:0]      blink_mask;
    logic [N-1:0]      dp_mask;
    logic [N-1:0]      an;
    logic [NB*8-1:0]   sseg;
    logic              frame_start;

    int checks = 0;
    int errors = 0;
    int j_model = 0;

    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] e;

    logic [N*4-1:0] snap_data;
    logic [N-1:0]   snap_blank;
    logic [N-1:0]   snap_blink;
    logic [N-1:0]   snap_dp;

    logic [6:0] seg_tab [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b1111111
    };

    seg_scan_driver #(
        .NUM_BANKS(NB), .DIGITS(D), .SCAN_DIV(SD), .BLINK_FRAMES(BF)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .digit_data(digit_data), .blank_mask(blank_mask),
        .blink_mask(blink_mask), .dp_mask(dp_mask),
        .an(an), .sseg(sseg), .frame_start(frame_start)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    // Predict the outputs after the coming edge from the current inputs.
    task automatic model_push();
        logic [N-1:0]    e_an;
        logic [NB*8-1:0] e_sseg;
        logic            e_fs;
        int t, dig, fr, bl, k;
        e_an   = '1;
        e_sseg = '1;
        e_fs   = 1'b0;
        if (reset || !enable) begin
            j_model = 0;
        end else begin
            j_model++;
            e_fs = (j_model == 1) || (j_model % (SD * D) == 0);
            if (j_model > 1) begin
                t   = j_model - 1;
                dig = (t / SD) % D;
                fr  = t / (SD * D);
                bl  = (fr / BF) % 2;
                for (int b = 0; b < NB; b++) begin
                    k = b * D + dig;
                    e_an[k] = 1'b0;
                    if (!(snap_blank[k] || (snap_blink[k] && bl == 1)))
                        e_sseg[b*8 +: 8] = {~snap_dp[k], seg_tab[snap_data[k*4 +: 4]]};
                end
            end
            if (e_fs) begin
                snap_data  = digit_data;
                snap_blank = blank_mask;
                snap_blink = blink_mask;
                snap_dp    = dp_mask;
            end
        end
        exp_q.push_back({e_an, e_sseg, e_fs});
    endtask

    // Driver: queue the prediction, take one edge, settle for sampling.
    task automatic drive_edge();
        model_push();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        enable     = 1'b1;
        digit_data = 32'($urandom);
        blank_mask = '0;
        blink_mask = '0;
        dp_mask    = '0;
        repeat (3) begin
            drive_edge();
            e = exp_q.pop_front();
            checks++;
            if ({an, sseg, frame_start} !== e || an !== 8'hFF || sseg !== 16'hFFFF) begin
                errors++;
                $display("FAIL reset_state an=%b/%b sseg=%h/%h fs=%b/%b",
                         an, e[EW-1 -: N], sseg, e[NB*8:1], frame_start, e[0]);
            end
        end
    endtask

    task automatic test_scan();
        digit_data = {16'h5678, 16'h1234};
        reset      = 1'b0;
        enable     = 1'b1;
        repeat (40) begin
            drive_edge();
            e = exp_q.pop_front();
            checks++;
            if ({an, sseg, frame_start} !== e) begin
                errors++;
                $display("FAIL scan j=%0d an=%b/%b sseg=%h/%h fs=%b/%b", j_model,
                         an, e[EW-1 -: N], sseg, e[NB*8:1], frame_start, e[0]);
            end
            if (j_model == 2) begin
                checks++;
                if (an !== 8'b1110_1110 || sseg[6:0] !== 7'b1001100 || sseg[14:8] !== 7'b0000000) begin
                    errors++;
                    $display("FAIL scan_first_digit an=%b/11101110 sseg=%h/(4 and 8 codes)", an, sseg);
                end
            end
        end
    endtask

    task automatic test_midframe_change();
        bit changed = 1'b0;
        repeat (40) begin
            if (!changed && (j_model % (SD * D)) == 6) begin
                digit_data = {16'h9ABC, 16'hDE01};
                changed    = 1'b1;
            end
            drive_edge();
            e = exp_q.pop_front();
            checks++;
            if ({an, sseg, frame_start} !== e) begin
                errors++;
                $display("FAIL midframe j=%0d an=%b/%b sseg=%h/%h fs=%b/%b", j_model,
                         an, e[EW-1 -: N], sseg, e[NB*8:1], frame_start, e[0]);
            end
        end
    endtask

    task automatic test_blank_blink_dp();
        reset = 1'b1;
        drive_edge();
        e = exp_q.pop_front();
        checks++;
        if ({an, sseg, frame_start} !== e) begin
            errors++;
            $display("FAIL blank_reset an=%b/%b sseg=%h/%h", an, e[EW-1 -: N], sseg, e[NB*8:1]);
        end
        reset      = 1'b0;
        digit_data = {16'hF3A1, 16'h0857};
        blank_mask = 8'b0000_0100;
        blink_mask = 8'b0000_0001;
        dp_mask    = 8'b0001_0001;
        repeat (72) begin
            drive_edge();
            e = exp_q.pop_front();
            checks++;
            if ({an, sseg, frame_start} !== e) begin
                errors++;
                $display("FAIL blank_blink j=%0d an=%b/%b sseg=%h/%h fs=%b/%b", j_model,
                         an, e[EW-1 -: N], sseg, e[NB*8:1], frame_start, e[0]);
            end
            if (j_model > 1 && ((j_model - 1) / SD) % D == 2) begin
                checks++;
                if (an[2] !== 1'b0 || sseg[7:0] !== 8'hFF) begin
                    errors++;
                    $display("FAIL blanked_digit an2=%b/0 sseg0=%h/ff", an[2], sseg[7:0]);
                end
            end
        end
    endtask

    task automatic test_enable();
        blank_mask = '0;
        blink_mask = '0;
        dp_mask    = 8'b1000_0010;
        repeat (6) begin
            drive_edge();
            e = exp_q.pop_front();
            checks++;
            if ({an, sseg, frame_start} !== e) begin
                errors++;
                $display("FAIL enable_pre an=%b/%b sseg=%h/%h", an, e[EW-1 -: N], sseg, e[NB*8:1]);
            end
        end
        enable     = 1'b0;
        digit_data = {16'h2468, 16'h1357};
        repeat (5) begin
            drive_edge();
            e = exp_q.pop_front();
            checks++;
            if ({an, sseg, frame_start} !== e || an !== 8'hFF || sseg !== 16'hFFFF) begin
                errors++;
                $display("FAIL enable_off an=%b/%b sseg=%h/%h", an, e[EW-1 -: N], sseg, e[NB*8:1]);
            end
        end
        enable = 1'b1;
        repeat (20) begin
            drive_edge();
            e = exp_q.pop_front();
            checks++;
            if ({an, sseg, frame_start} !== e) begin
                errors++;
                $display("FAIL enable_on j=%0d an=%b/%b sseg=%h/%h fs=%b/%b", j_model,
                         an, e[EW-1 -: N], sseg, e[NB*8:1], frame_start, e[0]);
            end
            if (j_model == 1) begin
                checks++;
                if (frame_start !== 1'b1) begin
                    errors++;
                    $display("FAIL reenable_fs fs=%b/1", frame_start);
                end
            end
            if (j_model == 2) begin
                checks++;
                if (an !== 8'b1110_1110 || sseg[6:0] !== 7'b0001111) begin
                    errors++;
                    $display("FAIL reenable_digit0 an=%b/11101110 sseg0=%b/0001111", an, sseg[6:0]);
                end
            end
        end
    endtask

    task automatic test_reset_midscan();
        repeat (7) begin
            drive_edge();
            e = exp_q.pop_front();
            checks++;
            if ({an, sseg, frame_start} !== e) begin
                errors++;
                $display("FAIL rst_mid_pre an=%b/%b sseg=%h/%h", an, e[EW-1 -: N], sseg, e[NB*8:1]);
            end
        end
        reset = 1'b1;
        drive_edge();
        e = exp_q.pop_front();
        checks++;
        if ({an, sseg, frame_start} !== e || an !== 8'hFF || sseg !== 16'hFFFF) begin
            errors++;
            $display("FAIL rst_mid an=%b/ff sseg=%h/ffff", an, sseg);
        end
        reset = 1'b0;
        repeat (20) begin
            drive_edge();
            e = exp_q.pop_front();
            checks++;
            if ({an, sseg, frame_start} !== e) begin
                errors++;
                $display("FAIL rst_mid_post j=%0d an=%b/%b sseg=%h/%h fs=%b/%b", j_model,
                         an, e[EW-1 -: N], sseg, e[NB*8:1], frame_start, e[0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        repeat (120) begin
            digit_data = 32'($urandom);
            blank_mask = 8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255));
            blink_mask = 8'($urandom_range(0, 255));
            dp_mask    = 8'($urandom_range(0, 255));
            enable     = ($urandom_range(0, 29) != 0);
            drive_edge();
            e = exp_q.pop_front();
            checks++;
            if ({an, sseg, frame_start} !== e) begin
                errors++;
                $display("FAIL back_to_back j=%0d an=%b/%b sseg=%h/%h fs=%b/%b", j_model,
                         an, e[EW-1 -: N], sseg, e[NB*8:1], frame_start, e[0]);
            end
        end
    endtask

    initial begin
        reset      = 1'b1;
        enable     = 1'b0;
        digit_data = '0;
        blank_mask = '0;
        blink_mask = '0;
        dp_mask    = '0;
        snap_data  = '0;
        snap_blank = '0;
        snap_blink = '0;
        snap_dp    = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_scan();
        test_midframe_change();
        test_blank_blink_dp();
        test_enable();
        test_reset_midscan();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
